instruction_fetch: RTL and testbench

Fetch stage of the single-cycle/pipelined RISC-V core: the initiator side of the instruction memory read interface. It owns the program counter, drives the 64-bit byte address to the instruction memory (combinational, word-indexed by `addr[63:2]`), and captures the returned 32-bit instruction. It hands `{pc, instr}` to decode over a valid/ready handshake, and handles branch/jump redirects, back-pressure and out-of-range fetch faults.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_out_reg.sv | 42 ++++
 rtl/instruction_fetch.sv | 114 +++++++++++
 tb/tb_instruction_fetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch stage
package fetch_pkg;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_RANGE    = 2'b01;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b10;
  localparam logic [63:0] PC_STEP        = 64'd4;
  localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_out_reg.sv
// rtl/fetch_out_reg.sv - holdable {pc, instr} output register towards decode
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q, valid_d;
  fetch_entry_t entry_q, entry_d;

  // Flush only drops the valid bit; stale pc/instr stay visible but unqualified.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (load_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end else if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, imem read, redirect and fault handling for the fetch stage
// Optional misaligned-redirect trap: IFETCH_MISALIGN_TRAP_EN
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] PC_RESET   = 64'h0,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fetch_count
);

  localparam logic [63:0] PC_LIMIT = 64'(IMEM_WORDS) << 2;

  logic [63:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [1:0]   code_q, code_d;
  logic [31:0]  count_q, count_d;
  logic         load, out_load, out_flush;
  logic [63:0]  redirect_tgt;
  logic         redirect_misalign;
  fetch_entry_t out_entry;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign redirect_tgt      = redirect_pc;
  assign redirect_misalign = |redirect_pc[1:0];
`else
  logic unused_low_bits;
  assign unused_low_bits   = ^redirect_pc[1:0];
  assign redirect_tgt      = {redirect_pc[63:2], 2'b00};
  assign redirect_misalign = 1'b0;
`endif

  assign load = !out_valid || out_ready;

  always_comb begin
    pc_d      = pc_q;
    fault_d   = fault_q;
    code_d    = code_q;
    out_load  = 1'b0;
    out_flush = 1'b0;
    if (redirect_valid) begin
      pc_d      = redirect_tgt;
      out_flush = 1'b1;
      if (redirect_misalign) begin
        fault_d = 1'b1;
        code_d  = FAULT_MISALIGN;
      end else if (redirect_tgt >= PC_LIMIT) begin
        fault_d = 1'b1;
        code_d  = FAULT_RANGE;
      end else begin
        fault_d = 1'b0;
        code_d  = FAULT_NONE;
      end
    end else if (load) begin
      // While faulted the output drains but nothing new is fetched.
      if (fault_q) begin
        out_flush = 1'b1;
      end else if (pc_q < PC_LIMIT) begin
        out_load = 1'b1;
        pc_d     = pc_q + PC_STEP;
      end else begin
        fault_d   = 1'b1;
        code_d    = FAULT_RANGE;
        out_flush = 1'b1;
      end
    end
  end

  assign count_d = count_q + {31'd0, out_valid && out_ready && !redirect_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PC_RESET;
      fault_q <= 1'b0;
      code_q  <= FAULT_NONE;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

  fetch_out_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (out_load),
    .flush_i (out_flush),
    .entry_i ('{pc: pc_q, instr: imem_instr}),
    .valid_o (out_valid),
    .entry_o (out_entry)
  );

  assign imem_addr   = pc_q;
  assign out_pc      = out_entry.pc;
  assign out_instr   = out_entry.instr;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized and directed bench for instruction_fetch against a reference model
module tb_instruction_fetch;

  localparam longint unsigned LIMIT = 64'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  longint unsigned m_pc, m_opc;
  logic [31:0]     m_instr, m_count;
  bit              m_valid, m_fault;
  logic [1:0]      m_code;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  instruction_fetch #(.PC_RESET(64'h0), .IMEM_WORDS(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault          (fault),
    .fault_code     (fault_code),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    longint unsigned tgt;
    bit mis;
    if (rst) begin
      m_pc = 0; m_valid = 0; m_opc = 0; m_instr = 0;
      m_fault = 0; m_code = 2'd0; m_count = 0;
    end else if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      tgt = redirect_pc;
      mis = (redirect_pc % 4) != 0;
`else
      tgt = redirect_pc - (redirect_pc % 4);
      mis = 0;
`endif
      m_pc = tgt;
      m_valid = 0;
      if (mis) begin m_fault = 1; m_code = 2'd2; end
      else if (tgt >= LIMIT) begin m_fault = 1; m_code = 2'd1; end
      else begin m_fault = 0; m_code = 2'd0; end
    end else begin
      bit can_take;
      can_take = !m_valid || out_ready;
      if (m_valid && out_ready) m_count = m_count + 1;
      if (can_take) begin
        if (m_fault) m_valid = 0;
        else if (m_pc < LIMIT) begin
          m_opc = m_pc;
          m_instr = mem[m_pc / 4];
          m_valid = 1;
          m_pc = m_pc + 4;
        end else begin
          m_fault = 1; m_code = 2'd1; m_valid = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("fault", {63'd0, fault}, {63'd0, m_fault});
    check("fault_code", {62'd0, fault_code}, {62'd0, m_code});
    check("fetch_count", {32'd0, fetch_count}, {32'd0, m_count});
    if (m_valid) begin
      check("out_pc", out_pc, m_opc);
      check("out_instr", {32'd0, out_instr}, {32'd0, m_instr});
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [63:0] rpc, input bit rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [63:0] exp_pc [4];
    logic [31:0] exp_in [4];
    exp_pc = '{64'd0, 64'd4, 64'd8, 64'd12};
    exp_in = '{32'h00700013, 32'h07600993, 32'h00100593, 32'h00B98B33};

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h00700013; mem[1] = 32'h07600993;
    mem[2] = 32'h00100593; mem[3] = 32'h00B98B33;
    mem[10] = 32'h00D50663; mem[255] = 32'h00000013;

    rst = 1; redirect_valid = 0; redirect_pc = 0; out_ready = 0;

    // reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_imem_addr", imem_addr, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);

    // streaming, 1/cycle
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1);
      check("stream_pc", out_pc, exp_pc[k]);
      check("stream_instr", {32'd0, out_instr}, {32'd0, exp_in[k]});
    end
    step(0, 0, 0, 1);
    check("count4", {32'd0, fetch_count}, 64'd4);

    // redirect to 40 while 16 pending: bubble, then target, 16 uncounted
    step(0, 1, 64'd40, 1);
    check("redir_bubble", {63'd0, out_valid}, 64'd0);
    step(0, 0, 0, 1);
    check("redir_pc", out_pc, 64'd40);
    check("redir_instr", {32'd0, out_instr}, 64'h00D50663);
    check("redir_count", {32'd0, fetch_count}, 64'd4);

    // stall at out_pc=8
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      check("stall_pc", out_pc, 64'd8);
      check("stall_instr", {32'd0, out_instr}, 64'h00100593);
      check("stall_addr", imem_addr, 64'd12);
    end
    step(0, 0, 0, 1);
    check("resume_pc", out_pc, 64'd12);

    // run off the end of memory
    step(0, 1, 64'd1016, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("last_pc", out_pc, 64'd1020);
    check("last_instr", {32'd0, out_instr}, 64'h00000013);
    step(0, 0, 0, 1);
    check("range_fault", {63'd0, fault}, 64'd1);
    check("range_code", {62'd0, fault_code}, 64'd1);
    check("range_valid", {63'd0, out_valid}, 64'd0);
    step(0, 0, 0, 1);
    step(0, 1, 64'd0, 1);
    check("fault_clear", {63'd0, fault}, 64'd0);

    // misaligned redirect
    step(0, 1, 64'd42, 1);
    step(0, 0, 0, 1);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("mis_code", {62'd0, fault_code}, 64'd2);
    check("mis_valid", {63'd0, out_valid}, 64'd0);
`else
    check("mis_pc", out_pc, 64'd40);
    check("mis_code", {62'd0, fault_code}, 64'd0);
`endif

    // reset while stalled with a valid output
    step(0, 1, 64'd0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    step(1, 0, 0, 0);
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_pc", out_pc, 64'd0);
    check("mid_rst_count", {32'd0, fetch_count}, 64'd0);
    step(0, 0, 0, 1);
    check("post_rst_pc", out_pc, 64'd0);
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      bit r, rv, rdy;
      logic [63:0] rpc;
      int sel;
      r   = ($urandom_range(99) == 0);
      rv  = ($urandom_range(9) == 0);
      rdy = ($urandom_range(3) != 0);
      sel = $urandom_range(9);
      if (sel < 6)      rpc = {54'd0, $urandom_range(255), 2'b00};
      else if (sel < 8) rpc = {54'd0, 8'($urandom), 2'($urandom)};
      else if (sel < 9) rpc = 64'd1008 + 64'($urandom_range(40));
      else              rpc = {$urandom, $urandom};
      step(r, rv, rpc, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
